stage2_pool_ctrl: RTL and testbench
===================================

STAGE2_POOL_CTRL -- requirements
Module: stage2_pool_ctrl

Interface
REQ-001 Parameter IN_W, default 8: conv feature-map width (pixels per row) fed to the pooling core.
REQ-002 Parameter IN_H, default 8: conv feature-map height (rows per frame).
REQ-003 Parameter POOL, default 2: pooling window size; the expected pooled output count is OUT_CNT = (IN_W/POOL)*(IN_H/POOL) = 16.
REQ-004 Parameter CI, default 3: channel count carried in parallel on each bus.
REQ-005 Parameter IBW, default 19: bits per channel sample.
REQ-006 Parameter DRAIN_TO, default 64: maximum DRAIN cycles before a timeout is declared.
REQ-007 clk  input  1  system clock; all logic on the rising edge.
REQ-008 reset_n  input  1  reset; asynchronous, active-low.
REQ-009 i_start  input  1  one-cycle frame start request.
REQ-010 o_busy  output  1  high in RUN and DRAIN.
REQ-011 o_done  output  1  one-cycle frame-complete pulse.
REQ-012 o_err  output  1  sticky protocol/timeout error flag.
REQ-013 i_conv_valid  input  1  conv pixel valid.
REQ-014 i_conv_fmap  input  CI*IBW  conv pixel, all channels in parallel.
REQ-015 o_pool_valid  output  1  valid to the pooling core.
REQ-016 o_pool_fmap  output  CI*IBW  pixel to the pooling core.
REQ-017 i_pool_ot_valid  input  1  pooled result valid from the pooling core.
REQ-018 i_pool_ot_fmap  input  CI*IBW  pooled result from the pooling core.
REQ-019 o_ot_valid  output  1  pooled result valid downstream.
REQ-020 o_ot_fmap  output  CI*IBW  pooled result downstream.
REQ-021 o_ot_last  output  1  marks the OUT_CNT-th pooled result of the frame, coincident with o_ot_valid.

Function
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-023 Transitions SHALL be: IDLE->RUN on i_start; RUN->DRAIN after the accept cycle of the IN_W*IN_H-th pixel; DRAIN->DONE when the output count reaches OUT_CNT or the DRAIN cycle counter reaches DRAIN_TO; DONE->IDLE unconditionally after 1 cycle.
REQ-024 In RUN, each i_conv_valid pixel SHALL be registered to o_pool_valid/o_pool_fmap with 1-cycle latency; o_pool_valid SHALL be 0 in every other state.
REQ-025 The column counter SHALL wrap from IN_W-1 to 0 and then increment the row counter; the row counter SHALL stop at IN_H-1.
REQ-026 i_conv_valid in IDLE, DRAIN or DONE SHALL be dropped and SHALL set o_err.
REQ-027 In RUN or DRAIN, i_pool_ot_valid SHALL be registered to o_ot_valid/o_ot_fmap with 1-cycle latency, and the output counter SHALL increment.
REQ-028 o_ot_last SHALL be 1 only when the forwarded result is output count OUT_CNT-1, counting from 0.
REQ-029 i_pool_ot_valid in IDLE or DONE, or any result beyond OUT_CNT, SHALL be dropped and SHALL set o_err.
REQ-030 A DRAIN timeout SHALL set o_err and still pass through DONE, pulsing o_done.
REQ-031 i_start while o_busy=1 or in DONE SHALL be ignored.
REQ-032 o_err SHALL clear only on reset or on an accepted i_start.
REQ-033 Pixel, output and DRAIN counters SHALL clear on an accepted i_start.
REQ-034 o_ot_fmap SHALL hold its last value when o_ot_valid=0.

Reset
REQ-035 Asserting reset_n low SHALL asynchronously force IDLE, clear all counters, and drive o_busy, o_done, o_err, o_pool_valid, o_ot_valid and o_ot_last to 0 and o_pool_fmap and o_ot_fmap to 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL be in IDLE with no o_done pulse.

Structure
REQ-037 CI, IBW, IN_W, IN_H and POOL defaults SHALL come from the shared stage2 CNN defines header.
REQ-038 The FSM state encodings SHALL be local constants.
REQ-039 One sub-module, stage2_pool_cnt (a parameterised wrap counter with a terminal flag), SHALL be instantiated for the column, row and output counters.

Verification
REQ-040 Nominal frame: i_start, then 64 back-to-back pixels, and the core returns 16 results -> 16 o_ot_valid, o_ot_last on the 16th, and o_done exactly 1 cycle after DONE entry with o_err=0.
REQ-041 Gapped input: 64 pixels with random 0-3 idle cycles between them -> column/row counters correct, DRAIN is entered only after pixel 64, and the same 16 outputs appear.
REQ-042 Timeout: the core returns only 15 results -> DRAIN lasts 64 cycles, then o_err=1 and the o_done pulse occurs.
REQ-043 Protocol errors: a 65th pixel in DRAIN, and i_pool_ot_valid in IDLE -> both are dropped and o_err=1 is held until the next i_start.
REQ-044 Reset after pixel 30 -> all outputs are 0 immediately and no o_done occurs; a subsequent full frame completes cleanly.
REQ-045 i_start pulsed during RUN -> ignored, with counters and output count unaffected.

Source files
------------

// File: rtl/stage2_pool_ctrl_pkg.sv
// Shared stage2 CNN defaults and a counter-width helper used by the pooling controller.
package stage2_pool_ctrl_pkg;

   localparam int unsigned STAGE2_CI       = 3;
   localparam int unsigned STAGE2_IBW      = 19;
   localparam int unsigned STAGE2_IN_W     = 8;
   localparam int unsigned STAGE2_IN_H     = 8;
   localparam int unsigned STAGE2_POOL     = 2;
   localparam int unsigned STAGE2_DRAIN_TO = 64;

   // Bits needed to hold values 0..n-1 (minimum 1).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stage2_pool_cnt.sv
// Parameterised 0..MAX counter with a terminal flag; wraps to 0 or saturates at MAX.
module stage2_pool_cnt
   import stage2_pool_ctrl_pkg::*;
#(
   parameter int unsigned MAX = 7,
   parameter bit          SAT = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   localparam int unsigned W = cnt_w(MAX + 1);

   logic [W-1:0] r_cnt;
   logic         w_tc;

   assign w_tc   = (r_cnt == W'(MAX));
   assign o_tc_c = w_tc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_tc) begin
         r_cnt <= r_cnt + W'(1);
      end else if (i_en && !SAT) begin
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/stage2_pool_ctrl.sv
// Frame controller around the stage2 pooling core: forwards conv pixels in, pooled results out,
// tracks frame progress and flags protocol/timeout errors.
module stage2_pool_ctrl
   import stage2_pool_ctrl_pkg::*;
#(
   parameter int unsigned IN_W     = STAGE2_IN_W,
   parameter int unsigned IN_H     = STAGE2_IN_H,
   parameter int unsigned POOL     = STAGE2_POOL,
   parameter int unsigned CI       = STAGE2_CI,
   parameter int unsigned IBW      = STAGE2_IBW,
   parameter int unsigned DRAIN_TO = STAGE2_DRAIN_TO
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_start,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   input  logic                i_conv_valid,
   input  logic [CI*IBW-1:0]   i_conv_fmap,
   output logic                o_pool_valid,
   output logic [CI*IBW-1:0]   o_pool_fmap,
   input  logic                i_pool_ot_valid,
   input  logic [CI*IBW-1:0]   i_pool_ot_fmap,
   output logic                o_ot_valid,
   output logic [CI*IBW-1:0]   o_ot_fmap,
   output logic                o_ot_last
);

   localparam int unsigned OUT_CNT = (IN_W / POOL) * (IN_H / POOL);
   localparam int unsigned DW      = cnt_w(DRAIN_TO);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_drain;
   logic          r_out_full;

   logic w_start_acc;
   logic w_pix_acc;
   logic w_res_acc;
   logic w_col_tc;
   logic w_row_tc;
   logic w_out_tc;
   logic w_last_pix;
   logic w_out_done;
   logic w_drain_to;
   logic w_err_set;

   assign w_start_acc = (r_state == S_IDLE) && i_start;
   assign w_pix_acc   = (r_state == S_RUN) && i_conv_valid;
   // Results are accepted while a frame is live and until OUT_CNT have been forwarded.
   assign w_res_acc   = ((r_state == S_RUN) || (r_state == S_DRAIN)) && i_pool_ot_valid
                        && !r_out_full;
   assign w_last_pix  = w_pix_acc && w_col_tc && w_row_tc;
   assign w_out_done  = r_out_full || (w_res_acc && w_out_tc);
   assign w_drain_to  = (r_state == S_DRAIN) && (r_drain == DW'(DRAIN_TO - 1));
   assign w_err_set   = (i_conv_valid && (r_state != S_RUN))
                        || (i_pool_ot_valid && !w_res_acc)
                        || (w_drain_to && !w_out_done);

   stage2_pool_cnt #(.MAX(IN_W - 1), .SAT(1'b0)) u_col_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_start_acc),
      .i_en    (w_pix_acc),
      .o_tc_c  (w_col_tc)
   );

   stage2_pool_cnt #(.MAX(IN_H - 1), .SAT(1'b1)) u_row_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_start_acc),
      .i_en    (w_pix_acc && w_col_tc),
      .o_tc_c  (w_row_tc)
   );

   stage2_pool_cnt #(.MAX(OUT_CNT - 1), .SAT(1'b0)) u_out_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_start_acc),
      .i_en    (w_res_acc),
      .o_tc_c  (w_out_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last_pix) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_out_done || w_drain_to) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs, drain timer and output-full flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_pool_valid <= 1'b0;
         o_pool_fmap  <= '0;
         o_ot_valid   <= 1'b0;
         o_ot_fmap    <= '0;
         o_ot_last    <= 1'b0;
         r_drain      <= '0;
         r_out_full   <= 1'b0;
      end else begin
         o_busy       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
         o_done       <= (r_state == S_DONE);
         o_err        <= (o_err && !w_start_acc) || w_err_set;
         o_pool_valid <= w_pix_acc;
         o_ot_valid   <= w_res_acc;
         o_ot_last    <= w_res_acc && w_out_tc;
         if (w_pix_acc) begin
            o_pool_fmap <= i_conv_fmap;
         end
         if (w_res_acc) begin
            o_ot_fmap <= i_pool_ot_fmap;
         end
         if (w_start_acc) begin
            r_drain    <= '0;
            r_out_full <= 1'b0;
         end else begin
            if (r_state == S_DRAIN) begin
               r_drain <= r_drain + DW'(1);
            end
            if (w_res_acc && w_out_tc) begin
               r_out_full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stage2_pool_ctrl.sv
// Randomized bench for stage2_pool_ctrl against a frame-level reference model.
module tb_stage2_pool_ctrl;

   localparam int IN_W     = 8;
   localparam int IN_H     = 8;
   localparam int POOL     = 2;
   localparam int CI       = 3;
   localparam int IBW      = 19;
   localparam int DRAIN_TO = 64;
   localparam int FW       = CI * IBW;
   localparam int NPIX     = IN_W * IN_H;
   localparam int OUT_CNT  = (IN_W / POOL) * (IN_H / POOL);

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_start = 1'b0;
   logic          o_busy, o_done, o_err;
   logic          i_conv_valid = 1'b0;
   logic [FW-1:0] i_conv_fmap = '0;
   logic          o_pool_valid;
   logic [FW-1:0] o_pool_fmap;
   logic          i_pool_ot_valid = 1'b0;
   logic [FW-1:0] i_pool_ot_fmap = '0;
   logic          o_ot_valid;
   logic [FW-1:0] o_ot_fmap;
   logic          o_ot_last;

   stage2_pool_ctrl #(
      .IN_W(IN_W), .IN_H(IN_H), .POOL(POOL), .CI(CI), .IBW(IBW), .DRAIN_TO(DRAIN_TO)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_start         (i_start),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_err           (o_err),
      .i_conv_valid    (i_conv_valid),
      .i_conv_fmap     (i_conv_fmap),
      .o_pool_valid    (o_pool_valid),
      .o_pool_fmap     (o_pool_fmap),
      .i_pool_ot_valid (i_pool_ot_valid),
      .i_pool_ot_fmap  (i_pool_ot_fmap),
      .o_ot_valid      (o_ot_valid),
      .o_ot_fmap       (o_ot_fmap),
      .o_ot_last       (o_ot_last)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   // Reference model: frame phase, pixel/result/drain tallies and expected outputs.
   int            m_st, m_pix, m_out, m_drain;
   bit            m_err;
   bit            e_busy, e_done, e_pv, e_ov, e_last;
   logic [FW-1:0] e_pf, e_of;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [FW-1:0] rnd_fmap();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[FW-1:0];
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_pix = 0; m_out = 0; m_drain = 0; m_err = 0;
      e_busy = 0; e_done = 0; e_pv = 0; e_ov = 0; e_last = 0;
      e_pf = '0; e_of = '0;
   endtask

   task automatic model_eval();
      int st0;
      st0    = m_st;
      e_done = (st0 == M_DONE);
      e_pv   = 0;
      e_ov   = 0;
      e_last = 0;
      if (st0 == M_IDLE && i_start) begin
         m_err = 0; m_pix = 0; m_out = 0; m_drain = 0;
      end
      if (i_conv_valid) begin
         if (st0 == M_RUN) begin
            e_pv = 1; e_pf = i_conv_fmap; m_pix++;
         end else begin
            m_err = 1;
         end
      end
      if (i_pool_ot_valid) begin
         if ((st0 == M_RUN || st0 == M_DRAIN) && m_out < OUT_CNT) begin
            e_ov = 1; e_of = i_pool_ot_fmap; e_last = (m_out == OUT_CNT - 1); m_out++;
         end else begin
            m_err = 1;
         end
      end
      case (st0)
         M_IDLE:  if (i_start) m_st = M_RUN;
         M_RUN:   if (e_pv && m_pix == NPIX) m_st = M_DRAIN;
         M_DRAIN: begin
            m_drain++;
            if (m_out == OUT_CNT) m_st = M_DONE;
            else if (m_drain == DRAIN_TO) begin m_err = 1; m_st = M_DONE; end
         end
         default: m_st = M_IDLE;
      endcase
      e_busy = (m_st == M_RUN) || (m_st == M_DRAIN);
   endtask

   task automatic check_all();
      int row;
      row = m_pix / IN_W;
      if (row > IN_H - 1) row = IN_H - 1;
      chk_eq("busy",       64'(o_busy),       64'(e_busy));
      chk_eq("done",       64'(o_done),       64'(e_done));
      chk_eq("err",        64'(o_err),        64'(m_err));
      chk_eq("pool_valid", 64'(o_pool_valid), 64'(e_pv));
      chk_eq("pool_fmap",  64'(o_pool_fmap),  64'(e_pf));
      chk_eq("ot_valid",   64'(o_ot_valid),   64'(e_ov));
      chk_eq("ot_fmap",    64'(o_ot_fmap),    64'(e_of));
      chk_eq("ot_last",    64'(o_ot_last),    64'(e_last));
      chk_eq("col_cnt",    64'(dut.u_col_cnt.r_cnt), 64'(m_pix % IN_W));
      chk_eq("row_cnt",    64'(dut.u_row_cnt.r_cnt), 64'(row));
      chk_eq("out_cnt",    64'(dut.u_out_cnt.r_cnt), 64'(m_out % OUT_CNT));
   endtask

   task automatic step();
      @(posedge clk);
      model_eval();
      #1;
      check_all();
      cyc++;
   endtask

   task automatic do_reset();
      i_start = 0; i_conv_valid = 0; i_pool_ot_valid = 0;
      reset_n = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset_n = 1;
   endtask

   // One frame: n_pix pixels with 0..max_gap idle cycles, core returns n_res results.
   task automatic run_frame(input int n_pix, input int n_res, input int max_gap,
                            input bit mid_start, input int rst_at);
      int sent = 0, gap = 0, issued = 0, budget = 0;
      int n_done = 0, n_ot = 0, n_last = 0;
      bit started = 0, fin = 0;
      int due[$];
      i_start = 1;
      step();
      i_start = 0;
      while (!fin && budget < 1000) begin
         i_conv_valid    = 0;
         i_pool_ot_valid = 0;
         if (sent < n_pix) begin
            if (gap == 0) begin
               i_conv_valid = 1;
               i_conv_fmap  = rnd_fmap();
               sent++;
               gap = int'($urandom_range(0, max_gap));
               if (sent % POOL**2 == 0 && issued < n_res) begin
                  due.push_back(cyc + int'($urandom_range(1, 6)));
                  issued++;
               end
            end else begin
               gap--;
            end
         end
         if (due.size() > 0 && due[0] <= cyc) begin
            void'(due.pop_front());
            i_pool_ot_valid = 1;
            i_pool_ot_fmap  = rnd_fmap();
         end
         if (mid_start && !started && sent == 20) begin
            i_start = 1;
            started = 1;
         end
         step();
         i_start = 0;
         budget++;
         if (o_done) n_done++;
         if (o_ot_valid) n_ot++;
         if (o_ot_valid && o_ot_last) n_last++;
         if (rst_at > 0 && sent == rst_at) begin
            do_reset();
            fin = 1;
         end else if (e_done) begin
            fin = 1;
         end
      end
      i_conv_valid    = 0;
      i_pool_ot_valid = 0;
      chk_eq("frame_budget", 64'(budget < 1000), 64'(1));
      if (rst_at > 0) begin
         chk_eq("done_after_reset", 64'(n_done), 64'(0));
      end else begin
         chk_eq("frame_done_cnt", 64'(n_done), 64'(1));
         chk_eq("frame_ot_cnt",   64'(n_ot),   64'(n_res));
         chk_eq("frame_last_cnt", 64'(n_last), 64'((n_res >= OUT_CNT) ? 1 : 0));
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset_n = 1;
      repeat (3) step();

      run_frame(NPIX, OUT_CNT, 0, 1'b0, 0);
      chk_eq("err_nominal", 64'(o_err), 64'(0));
      repeat (2) step();

      run_frame(NPIX, OUT_CNT, 3, 1'b0, 0);
      chk_eq("err_gapped", 64'(o_err), 64'(0));

      run_frame(NPIX, OUT_CNT - 1, 0, 1'b0, 0);
      chk_eq("err_timeout", 64'(o_err), 64'(1));
      repeat (2) step();

      run_frame(NPIX + 1, OUT_CNT, 0, 1'b0, 0);
      chk_eq("err_pixel65", 64'(o_err), 64'(1));
      i_pool_ot_valid = 1;
      i_pool_ot_fmap  = rnd_fmap();
      step();
      i_pool_ot_valid = 0;
      repeat (4) step();
      chk_eq("err_held", 64'(o_err), 64'(1));

      run_frame(NPIX, OUT_CNT, 1, 1'b1, 0);
      chk_eq("err_cleared", 64'(o_err), 64'(0));

      run_frame(NPIX, OUT_CNT, 0, 1'b0, 30);
      repeat (3) step();
      run_frame(NPIX, OUT_CNT, 2, 1'b0, 0);
      chk_eq("err_after_reset", 64'(o_err), 64'(0));

      for (int k = 0; k < 3; k++) begin
         run_frame(NPIX, int'($urandom_range(OUT_CNT - 2, OUT_CNT)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
         repeat (2) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
